npu_host_master: RTL



---
 rtl/npu_host_master_pkg.sv | 33 +++
 rtl/npu_bus_xfer.sv | 76 +++++++
 rtl/npu_host_master.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/npu_host_master_pkg.sv
// Shared constants, FSM encoding and address helpers for the NPU host master.
package npu_host_master_pkg;

  localparam logic [31:0] NPU_CTRL_ADDR = 32'h0002_0000;
  localparam int          NPU_CMD_RUN   = 0;
  localparam int          NPU_CMD_STOP  = 1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD_RD   = 4'd1,
    ST_LOAD_WAIT = 4'd2,
    ST_WR        = 4'd3,
    ST_START     = 4'd4,
    ST_GAP       = 4'd5,
    ST_POLL      = 4'd6,
    ST_DONE      = 4'd7,
    ST_TOUT      = 4'd8
  } state_e;

  // NPU memory word index to byte address; bit 17 stays clear so memory never aliases the control register.
  function automatic logic [31:0] word_to_byte(input logic [14:0] w);
    return {14'b0, 1'b0, w, 2'b00};
  endfunction

  function automatic logic [31:0] start_cmd(input logic [15:0] seq_addr);
    logic [15:0] ctl;
    ctl               = '0;
    ctl[NPU_CMD_RUN]  = 1'b1;
    ctl[NPU_CMD_STOP] = 1'b0;
    return {seq_addr, ctl};
  endfunction

endpackage

// File: rtl/npu_bus_xfer.sv
// Single NPU bus transaction engine: registers one request and holds it until ready.
module npu_bus_xfer (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        valid,
  input  logic        ready,
  output logic [3:0]  wstrb,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        xfer_done,
  output logic [31:0] xfer_rdata
);

  // Handshake: valid/addr/wstrb/wdata are frozen from the cycle valid rises until ready is
  // sampled high; valid then drops, xfer_done pulses for one cycle, and while xfer_done is
  // high a new request is refused, so valid is low for at least one cycle between transfers.
  // ready seen while valid is low is ignored.
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    valid_d = valid_q;
    done_d  = 1'b0;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (valid_q) begin
      if (ready) begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        rdata_d = rdata;
      end
    end else if (req && !done_q) begin
      valid_d = 1'b1;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      wstrb_d = req_write ? 4'b1111 : 4'b0000;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign valid      = valid_q;
  assign wstrb      = wstrb_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign xfer_done  = done_q;
  assign xfer_rdata = rdata_q;

endmodule

// File: rtl/npu_host_master.sv
// Copies a block of words from a local RAM into NPU memory, optionally starts the sequencer and polls for idle.
module npu_host_master
  import npu_host_master_pkg::*;
#(
  parameter int SRC_AW     = 12,
  parameter int POLL_GAP   = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SRC_AW-1:0] cmd_src,
  input  logic [14:0]       cmd_dst,
  input  logic [15:0]       cmd_len,
  input  logic              cmd_run,
  input  logic [15:0]       cmd_seq_addr,
  output logic              src_ren,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [31:0]       src_rdata,
  output logic              valid,
  input  logic              ready,
  output logic [3:0]        wstrb,
  output logic [31:0]       addr,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [3:0]        dbg_state
);

  localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);
  localparam logic [15:0] LIMIT_W   = 16'(POLL_LIMIT);

  state_e            state_q, state_d;
  logic [SRC_AW-1:0] src_q, src_d;
  logic [14:0]       dst_q, dst_d;
  logic [15:0]       rem_q, rem_d;
  logic              run_q, run_d;
  logic [15:0]       seq_q, seq_d;
  logic [31:0]       data_q, data_d;
  logic [15:0]       polls_q, polls_d;
  logic [15:0]       gap_q, gap_d;
  logic              src_ren_q, src_ren_d;
  logic              busy_q, busy_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              done_q, done_d;
  logic              tout_q, tout_d;

  logic              bus_req, bus_write;
  logic [31:0]       bus_addr, bus_wdata;
  logic              xfer_done;
  logic [31:0]       xfer_rdata;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    run_d     = run_q;
    seq_d     = seq_q;
    data_d    = data_q;
    polls_d   = polls_q;
    gap_d     = gap_q;
    bus_req   = 1'b0;
    bus_write = 1'b0;
    bus_addr  = NPU_CTRL_ADDR;
    bus_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          rem_d   = cmd_len;
          run_d   = cmd_run;
          seq_d   = cmd_seq_addr;
          polls_d = '0;
          if (cmd_len != 16'd0) state_d = ST_LOAD_RD;
          else if (cmd_run)     state_d = ST_START;
          else                  state_d = ST_DONE;
        end
      end
      ST_LOAD_RD: state_d = ST_LOAD_WAIT;
      ST_LOAD_WAIT: begin
        data_d  = src_rdata;
        state_d = ST_WR;
      end
      ST_WR: begin
        bus_req   = 1'b1;
        bus_write = 1'b1;
        bus_addr  = word_to_byte(dst_q);
        bus_wdata = data_q;
        if (xfer_done) begin
          dst_d = dst_q + 15'd1;
          src_d = src_q + SRC_AW'(1);
          rem_d = rem_q - 16'd1;
          if (rem_q != 16'd1) state_d = ST_LOAD_RD;
          else if (run_q)     state_d = ST_START;
          else                state_d = ST_DONE;
        end
      end
      ST_START: begin
        bus_req   = 1'b1;
        bus_write = 1'b1;
        bus_wdata = start_cmd(seq_q);
        if (xfer_done) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_POLL;
        else                   gap_d   = gap_q + 16'd1;
      end
      ST_POLL: begin
        bus_req = 1'b1;
        if (xfer_done) begin
          if (polls_q != 16'hFFFF) polls_d = polls_q + 16'd1;
          gap_d = '0;
          // A zero status ends the command even on the last allowed poll.
          if (xfer_rdata == 32'd0)                         state_d = ST_DONE;
          else if (POLL_LIMIT != 0 && polls_d == LIMIT_W) state_d = ST_TOUT;
          else                                             state_d = ST_GAP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_TOUT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    src_ren_d   = (state_d == ST_LOAD_RD);
    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
    done_d      = (state_d == ST_DONE);
    tout_d      = (state_d == ST_TOUT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      run_q       <= 1'b0;
      seq_q       <= '0;
      data_q      <= '0;
      polls_q     <= '0;
      gap_q       <= '0;
      src_ren_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      run_q       <= run_d;
      seq_q       <= seq_d;
      data_q      <= data_d;
      polls_q     <= polls_d;
      gap_q       <= gap_d;
      src_ren_q   <= src_ren_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      tout_q      <= tout_d;
    end
  end

  npu_bus_xfer u_xfer (
    .clock      (clock),
    .reset      (reset),
    .req        (bus_req),
    .req_write  (bus_write),
    .req_addr   (bus_addr),
    .req_wdata  (bus_wdata),
    .valid      (valid),
    .ready      (ready),
    .wstrb      (wstrb),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .xfer_done  (xfer_done),
    .xfer_rdata (xfer_rdata)
  );

  assign cmd_ready = cmd_ready_q;
  assign src_ren   = src_ren_q;
  assign src_addr  = src_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = tout_q;
  assign dbg_state = state_q;

endmodule
